// File: rtl/lagarto0_pkg.sv
// Shared front-end constants and types for the instruction queue.
// The queue top and its storage both import this package.
package lagarto0_pkg;

    localparam int IQUEUE_DEPTH     = 8;
    localparam int IQUEUE_ADDR_SIZE = $clog2(IQUEUE_DEPTH);
    localparam int ICACHE_LINE_SIZE = 128;
    localparam int IQUEUE_AF_MARGIN = 1;

    // Accepted-operation kind for a cycle, used to steer the occupancy counter
    typedef enum logic [1:0] {
        Q_IDLE = 2'b00,
        Q_POP  = 2'b01,
        Q_PUSH = 2'b10,
        Q_BOTH = 2'b11
    } iqueue_op_e;

    function automatic iqueue_op_e iqueue_op(input logic push, input logic pop);
        return iqueue_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/iqueue_mem.sv
// Instruction queue storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately never reset.
module iqueue_mem
    import lagarto0_pkg::*;
#(
    parameter int DEPTH = IQUEUE_DEPTH,
    parameter int WIDTH = ICACHE_LINE_SIZE,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/iqueue_param.sv
// Parameterised instruction queue: circular buffer with occupancy flags,
// overflow/underflow pulses, flush, and registered or fall-through read data.
module iqueue_param
    import lagarto0_pkg::*;
#(
    parameter int DEPTH     = IQUEUE_DEPTH,
    parameter int WIDTH     = ICACHE_LINE_SIZE,
    parameter int FWFT      = 0,
    parameter int AF_MARGIN = IQUEUE_AF_MARGIN,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [AW:0]      count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_full_o,
    output logic             ovf_o,
    output logic             udf_o
);

    // A threshold of zero (margin >= depth) makes almost_full permanently high
    localparam int            AF_TH   = (DEPTH > AF_MARGIN) ? (DEPTH - AF_MARGIN) : 0;
    localparam logic [AW:0]   AF_TH_V = (AW+1)'(AF_TH);
    localparam logic [AW:0]   FULL_V  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             ovf_q;
    logic             udf_q;
    logic             push;
    logic             pop;
    iqueue_op_e       op;
    logic [WIDTH-1:0] head_data;

    assign full_o        = (count_q == FULL_V);
    assign empty_o       = (count_q == '0);
    assign almost_full_o = (count_q >= AF_TH_V);
    assign count_o       = count_q;
    assign ovf_o         = ovf_q;
    assign udf_o         = udf_q;

    always_comb begin
        push = wr_i && !full_o && !flush_i;
        pop  = rd_i && !empty_o && !flush_i;
        op   = iqueue_op(push, pop);
    end

    iqueue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk_i (clk_i),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (data_i),
        .raddr (rd_ptr_q),
        .rdata (head_data)
    );

    // Flush beats any request and suppresses the error pulses for that cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            ovf_q <= wr_i && full_o;
            udf_q <= rd_i && empty_o;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case (op)
                Q_PUSH:  count_q <= count_q + CNT_ONE;
                Q_POP:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_o  = head_data;
            assign valid_o = !empty_o;
        end else begin : g_registered
            logic [WIDTH-1:0] data_q;
            logic             valid_q;

            // Read data is held across flushes; only the valid strobe drops
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= pop;
                    if (pop) begin
                        data_q <= head_data;
                    end
                end
            end

            assign data_o  = data_q;
            assign valid_o = valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_iqueue_param.sv
// Checks a registered-output and a fall-through queue side by side against
// a queue-based reference model, with directed scenarios then random traffic.
module tb_iqueue_param;

    localparam int DEPTH     = 4;
    localparam int WIDTH     = 8;
    localparam int AF_MARGIN = 1;

    logic       clk_i   = 1'b0;
    logic       rst_ni  = 1'b1;
    logic       flush_i = 1'b0;
    logic       wr_i    = 1'b0;
    logic       rd_i    = 1'b0;
    logic [7:0] data_i  = 8'h00;

    logic [7:0] data0, data1;
    logic       valid0, valid1;
    logic [2:0] count0, count1;
    logic       full0, full1, empty0, empty1, af0, af1;
    logic       ovf0, ovf1, udf0, udf1;

    int compareCount  = 0;
    int mismatchCount = 0;

    logic [7:0] modelQ[$];
    logic       expOvf;
    logic       expUdf;
    logic       expValid0;
    logic [7:0] expData0;

    always #5 clk_i = ~clk_i;

    iqueue_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(0), .AF_MARGIN(AF_MARGIN)) dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .wr_i(wr_i), .data_i(data_i),
        .rd_i(rd_i), .data_o(data0), .valid_o(valid0), .count_o(count0), .full_o(full0),
        .empty_o(empty0), .almost_full_o(af0), .ovf_o(ovf0), .udf_o(udf0)
    );

    iqueue_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(1), .AF_MARGIN(AF_MARGIN)) dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .wr_i(wr_i), .data_i(data_i),
        .rd_i(rd_i), .data_o(data1), .valid_o(valid1), .count_o(count1), .full_o(full1),
        .empty_o(empty1), .almost_full_o(af1), .ovf_o(ovf1), .udf_o(udf1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        expOvf    = 1'b0;
        expUdf    = 1'b0;
        expValid0 = 1'b0;
        expData0  = 8'h00;
    endtask

    task automatic modelStep(input logic w, input logic r, input logic f, input logic [7:0] d);
        int  n;
        logic pushOk, popOk;
        n = modelQ.size();
        if (f) begin
            modelQ.delete();
            expOvf    = 1'b0;
            expUdf    = 1'b0;
            expValid0 = 1'b0;
        end else begin
            pushOk    = w && (n < DEPTH);
            popOk     = r && (n > 0);
            expOvf    = w && (n == DEPTH);
            expUdf    = r && (n == 0);
            expValid0 = popOk;
            if (popOk) begin
                expData0 = modelQ.pop_front();
            end
            if (pushOk) begin
                modelQ.push_back(d);
            end
        end
    endtask

    task automatic checkAll();
        int n;
        n = modelQ.size();
        checkOutput("count_reg",  32'(count0), 32'(n));
        checkOutput("count_fwft", 32'(count1), 32'(n));
        checkOutput("full_reg",   32'(full0),  32'(n == DEPTH));
        checkOutput("full_fwft",  32'(full1),  32'(n == DEPTH));
        checkOutput("empty_reg",  32'(empty0), 32'(n == 0));
        checkOutput("empty_fwft", 32'(empty1), 32'(n == 0));
        checkOutput("af_reg",     32'(af0),    32'(n >= DEPTH - AF_MARGIN));
        checkOutput("af_fwft",    32'(af1),    32'(n >= DEPTH - AF_MARGIN));
        checkOutput("ovf_reg",    32'(ovf0),   32'(expOvf));
        checkOutput("ovf_fwft",   32'(ovf1),   32'(expOvf));
        checkOutput("udf_reg",    32'(udf0),   32'(expUdf));
        checkOutput("udf_fwft",   32'(udf1),   32'(expUdf));
        checkOutput("valid_reg",  32'(valid0), 32'(expValid0));
        checkOutput("data_reg",   32'(data0),  32'(expData0));
        checkOutput("valid_fwft", 32'(valid1), 32'(n > 0));
        if (n > 0) begin
            checkOutput("data_fwft", 32'(data1), 32'(modelQ[0]));
        end
    endtask

    // Outputs are checked on the falling edge, then the next inputs are driven
    task automatic applyStimulus(input logic w, input logic r, input logic f, input logic [7:0] d);
        @(negedge clk_i);
        checkAll();
        wr_i    = w;
        rd_i    = r;
        flush_i = f;
        data_i  = d;
        @(posedge clk_i);
        modelStep(w, r, f, d);
    endtask

    initial begin
        logic [7:0] pushSeq [5];
        pushSeq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        #2 rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        modelReset();
        checkAll();
        rst_ni = 1'b1;

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, pushSeq[i]);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'hA1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hA2);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'hAA);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h5A);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'hB0 + 8'(i));
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hEE);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h77);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                          $urandom_range(0, 31) == 0, 8'($urandom));
        end

        // Asynchronous reset asserted between clock edges in the middle of traffic
        applyStimulus(1'b1, 1'b0, 1'b0, 8'hC1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hC2);
        @(negedge clk_i);
        checkAll();
        wr_i   = 1'b1;
        rd_i   = 1'b1;
        data_i = 8'hC3;
        #2 rst_ni = 1'b0;
        #1;
        modelReset();
        checkAll();
        wr_i = 1'b0;
        rd_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 60; i++) begin
            applyStimulus($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45,
                          $urandom_range(0, 31) == 0, 8'($urandom));
        end

        @(negedge clk_i);
        checkAll();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/iqueue_param.md
IQUEUE_PARAM -- requirements
Module: iqueue_param

Interface
REQ-001 SHALL have parameters:
- DEPTH, IQUEUE_DEPTH, entry count; power of two, >= 2.
- WIDTH, ICACHE_LINE_SIZE, entry width in bits.
- FWFT, 0, 0 = registered read data, 1 = first-word-fall-through.
- AF_MARGIN, 1, almost_full_o asserts when free entries <= AF_MARGIN.
REQ-002 SHALL use AW = $clog2(DEPTH) internally.
REQ-003 SHALL have ports:
- clk_i  in  1  sole clock, rising edge.
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
- flush_i  in  1  synchronous queue flush (e.g. branch redirect).
- wr_i  in  1  push request.
- data_i  in  WIDTH  push data.
- rd_i  in  1  pop request.
- data_o  out  WIDTH  pop data.
- valid_o  out  1  data_o holds a valid entry.
- count_o  out  AW+1  occupied entries, 0..DEPTH.
- full_o  out  1  count_o == DEPTH.
- empty_o  out  1  count_o == 0.
- almost_full_o  out  1  count_o >= DEPTH-AF_MARGIN.
- ovf_o  out  1  one-cycle pulse: write attempted while full.
- udf_o  out  1  one-cycle pulse: read attempted while empty.

Function
REQ-004 Push accepted iff wr_i && !full_o && !flush_i; entry written at write pointer, pointer +1 mod DEPTH.
REQ-005 Pop accepted iff rd_i && !empty_o && !flush_i; read pointer +1 mod DEPTH.
REQ-006 Push and pop SHALL both be accepted in the same cycle; count_o unchanged, data order preserved.
REQ-007 Write while full SHALL be dropped and pulse ovf_o next cycle; read while empty SHALL leave state unchanged and pulse udf_o next cycle.
REQ-008 count_o SHALL update on the edge after accepted operations: +1 push only, -1 pop only, else hold.
REQ-009 full_o, empty_o, almost_full_o SHALL be combinational decodes of the count register.
REQ-010 FWFT=0: data_o registered, loaded with head entry on edge of accepted pop, held otherwise; valid_o pulses 1 cycle after each accepted pop.
REQ-011 FWFT=1: data_o = head entry combinationally; valid_o = !empty_o; pop advances head with zero latency.
REQ-012 flush_i SHALL take priority over wr_i/rd_i: next cycle pointers and count = 0, valid_o = 0; storage contents and FWFT=0 data_o value not cleared; no ovf_o/udf_o from a flush cycle.
REQ-013 Pointers SHALL wrap DEPTH-1 -> 0 with no gap or duplicate entry.

Reset
REQ-014 On rst_ni low, asynchronously: pointers 0, count_o 0, empty_o 1, full_o 0, almost_full_o 0 (unless DEPTH-AF_MARGIN <= 0), valid_o 0, ovf_o 0, udf_o 0, FWFT=0 data_o 0.
REQ-015 Storage array SHALL not be reset; reset mid-operation discards all entries.

Structure
REQ-016 lagarto0_pkg SHALL hold IQUEUE_DEPTH, IQUEUE_ADDR_SIZE, ICACHE_LINE_SIZE, and new IQUEUE_AF_MARGIN.
REQ-017 Storage SHALL be a sub-module iqueue_mem (1 write, 1 async read port, DEPTH x WIDTH); control, pointers, count, flags in iqueue_param.

Verification (DEPTH=4, WIDTH=8, AF_MARGIN=1)
REQ-018 Reset, then push 0x11,0x22,0x33,0x44 -> count_o 1..4, almost_full_o at count 3, full_o at 4; push 0x55 -> ovf_o 1 cycle, count_o stays 4.
REQ-019 FWFT=0: pop x4 -> data_o 0x11,0x22,0x33,0x44 each one cycle after pop with valid_o; 5th pop -> udf_o pulse, empty_o 1.
REQ-020 Count 2, simultaneous wr_i(0xAA)+rd_i for 6 cycles -> count_o stays 2, pointers wrap, output order intact.
REQ-021 FWFT=1: push 0x5A into empty -> data_o 0x5A, valid_o 1 the cycle after push; pop -> valid_o 0 same cycle as count_o 0.
REQ-022 Count 3, flush_i with wr_i and rd_i high -> next cycle count_o 0, empty_o 1, no ovf_o/udf_o; next push 0x77 reads back 0x77.
REQ-023 rst_ni low mid-burst between edges -> outputs reach reset values before next clk_i edge.
